// File: rtl/down_counter.sv
// down_counter: loadable start/stop down counter, IDLE/RUN/DONE FSM.
// Ports: clock, reset (async, active low), load, load_value, start, stop,
//   enable in; count, busy, zero, done out.
//   Priority per edge: load > stop > start > enable.
//   Define DOWN_COUNTER_RELOAD_EN to make the count reload at terminal
//   count and keep running periodically instead of stopping in DONE.
module down_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             stop,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             zero,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic [WIDTH-1:0] reload_reg;
   logic [WIDTH-1:0] reload_nxt;
   logic             done_nxt;
   logic             last_step;

   // Only 1 is a legal terminal value in RUN; 0 is folded in so a
   // corrupted count can never wrap through the decrement.
   assign last_step = (count <= WIDTH'(1));

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      reload_nxt = reload_reg;
      done_nxt   = 1'b0;
      if (load) begin
         count_nxt  = load_value;
         reload_nxt = load_value;
         state_nxt  = IDLE;
      end else if (stop) begin
         if (state == RUN)
            state_nxt = IDLE;
      end else if (start && state != RUN) begin
         if (state == IDLE) begin
            if (count != '0) begin
               state_nxt = RUN;
            end else begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end
         end else begin
            if (reload_reg != '0) begin
               count_nxt = reload_reg;
               state_nxt = RUN;
            end else begin
               done_nxt = 1'b1;
            end
         end
      end else if (enable && state == RUN) begin
         if (!last_step) begin
            count_nxt = count - WIDTH'(1);
         end else begin
            done_nxt = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
            count_nxt = reload_reg;
`else
            count_nxt = '0;
            state_nxt = DONE;
`endif
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         reload_reg <= '0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         reload_reg <= reload_nxt;
         done       <= done_nxt;
      end
   end

   assign busy = (state == RUN);
   assign zero = (count == '0);

endmodule
